// File: rtl/pci_arbiter_pkg.sv
// Shared definitions for the four-master PCI bus arbiter.
// The ARB_TIMEOUT_EN latency counter uses the same counter width as the no-show timer.
package pci_arb_pkg;

    localparam int NUM_MASTERS = 4;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2,
        TURN  = 2'd3
    } arb_state_t;

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [1:0] idx);
        return NUM_MASTERS'(1) << idx;
    endfunction

endpackage

// File: rtl/pci_arbiter_if.sv
// Request/grant and bus-status signals between the PCI masters and the arbiter.
interface pci_arbiter_if;
    import pci_arb_pkg::*;

    logic [NUM_MASTERS-1:0] req_n;
    logic                   frame_n;
    logic                   irdy_n;
    logic [NUM_MASTERS-1:0] gnt_n;
    logic [1:0]             owner;
    logic                   bus_busy;
    logic                   timeout;

    modport master (
        output req_n, frame_n, irdy_n,
        input  gnt_n, owner, bus_busy, timeout
    );

    modport slave (
        input  req_n, frame_n, irdy_n,
        output gnt_n, owner, bus_busy, timeout
    );

endinterface

// File: rtl/pci_arbiter_rr_picker.sv
// Combinational round-robin picker: searches last+1, last+2, last+3, last (mod 4).
module rr_picker
    import pci_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [1:0]             last,
    output logic [1:0]             winner,
    output logic                   valid
);

    logic [1:0] idx;

    always_comb begin
        winner = last;
        valid  = 1'b0;
        idx    = last;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = last + 2'(i);
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pci_arbiter.sv
// Four-master PCI arbiter: round-robin grant in IDLE, no-show timer, one-cycle turnaround.
// Define ARB_TIMEOUT_EN to add the ownership latency timeout while other masters wait.
module pci_arbiter
    import pci_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int NOSHOW_CYCLES  = 16
)
(
    input  logic          clk,
    input  logic          reset,
    pci_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] NOSHOW_LAST = CNT_W'(NOSHOW_CYCLES - 1);

    arb_state_t             state, state_next;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_next;
    logic [1:0]             owner_q, owner_next;
    logic                   timeout_q, timeout_next;
    logic [CNT_W-1:0]       noshow_cnt, noshow_next;

    logic [1:0] winner;
    logic       winner_valid;
    logic       grant_on;
    logic       owner_released;
    logic       bus_idle;
    logic       noshow_fire;
    logic       lat_fire;

    rr_picker u_picker (
        .req    (~bus.req_n),
        .last   (owner_q),
        .winner (winner),
        .valid  (winner_valid)
    );

    assign grant_on       = (gnt_q != '1);
    assign owner_released = bus.req_n[owner_q];
    assign bus_idle       = bus.frame_n & bus.irdy_n;
    assign noshow_fire    = (noshow_cnt == NOSHOW_LAST);

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] lat_cnt, lat_next;
    logic             other_req;

    // Ownership time only accrues while someone else is actually waiting for the bus.
    assign other_req = |(~bus.req_n & ~onehot(owner_q));
    assign lat_fire  = grant_on && other_req && (lat_cnt == LAT_LAST);

    always_comb begin
        lat_next = lat_cnt;
        if (state == IDLE || state == TURN) begin
            lat_next = '0;
        end else if (grant_on && other_req && !lat_fire) begin
            lat_next = lat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_cnt <= '0;
        end else begin
            lat_cnt <= lat_next;
        end
    end
`else
    assign lat_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gnt_q      <= '1;
            owner_q    <= 2'd3;
            timeout_q  <= 1'b0;
            noshow_cnt <= '0;
        end else begin
            state      <= state_next;
            gnt_q      <= gnt_next;
            owner_q    <= owner_next;
            timeout_q  <= timeout_next;
            noshow_cnt <= noshow_next;
        end
    end

    // BUSY may drop the grant and reach TURN on the same edge once the bus is already idle.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (winner_valid) state_next = GRANT;
            end
            GRANT: begin
                if (lat_fire || !bus.frame_n) begin
                    state_next = BUSY;
                end else if (owner_released || noshow_fire) begin
                    state_next = TURN;
                end
            end
            BUSY: begin
                if ((!grant_on || owner_released || lat_fire) && bus_idle) begin
                    state_next = TURN;
                end
            end
            TURN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        gnt_next     = gnt_q;
        owner_next   = owner_q;
        timeout_next = 1'b0;
        noshow_next  = noshow_cnt;
        case (state)
            IDLE: begin
                noshow_next = '0;
                gnt_next    = '1;
                if (winner_valid) begin
                    gnt_next   = ~onehot(winner);
                    owner_next = winner;
                end
            end
            GRANT: begin
                if (lat_fire) begin
                    gnt_next     = '1;
                    timeout_next = 1'b1;
                end else if (bus.frame_n) begin
                    if (owner_released) begin
                        gnt_next = '1;
                    end else if (noshow_fire) begin
                        gnt_next     = '1;
                        timeout_next = 1'b1;
                    end else begin
                        noshow_next = noshow_cnt + 1'b1;
                    end
                end
            end
            BUSY: begin
                noshow_next = '0;
                if (lat_fire) begin
                    gnt_next     = '1;
                    timeout_next = 1'b1;
                end else if (owner_released) begin
                    gnt_next = '1;
                end
            end
            default: begin
                gnt_next    = '1;
                noshow_next = '0;
            end
        endcase
    end

    assign bus.gnt_n    = gnt_q;
    assign bus.owner    = owner_q;
    assign bus.timeout  = timeout_q;
    assign bus.bus_busy = ~bus_idle;

endmodule

// File: doc/pci_arbiter.md
PCI_ARBITER -- requirements
Module: pci_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: ownership cycles allowed while another master waits (used only with ARB_TIMEOUT_EN).
REQ-002 Parameter NOSHOW_CYCLES, default 16: cycles a granted master has to assert frame_n before the grant is withdrawn.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port req_n, input, 4: active-low bus requests, masters 0..3.
REQ-006 Port frame_n, input, 1: active-low bus FRAME.
REQ-007 Port irdy_n, input, 1: active-low bus IRDY.
REQ-008 Port gnt_n, output, 4: active-low grants, registered, one-cold or all-ones.
REQ-009 Port owner, output, 2: index of the last-granted master.
REQ-010 Port bus_busy, output, 1: high while frame_n=0 or irdy_n=0.
REQ-011 Port timeout, output, 1: one-cycle pulse on a forced grant removal (no-show or latency timeout).

Function
REQ-012 The FSM SHALL have states IDLE, GRANT, BUSY and TURN.
REQ-013 In IDLE with any req_n low, the next edge SHALL drive gnt_n low for the round-robin winner, load owner, and enter GRANT (1-cycle request-to-grant latency).
REQ-014 The round-robin search order SHALL be owner+1, owner+2, owner+3, owner (mod 4).
REQ-015 In IDLE with no request, gnt_n SHALL be 4'b1111 (no parking).
REQ-016 In GRANT, frame_n=0 SHALL move the FSM to BUSY with the grant held.
REQ-017 In GRANT, if req_n[owner]=1 before frame_n falls, gnt_n SHALL go to all-ones on the next edge and the FSM SHALL enter TURN.
REQ-018 In BUSY, req_n[owner]=1 SHALL deassert the grant on the next edge.
REQ-019 In BUSY, the FSM SHALL leave for TURN only when the grant is deasserted and frame_n=1 and irdy_n=1.
REQ-020 TURN SHALL last exactly 1 cycle with gnt_n=4'b1111, then go to IDLE.
REQ-021 The minimum gap from bus idle to the next grant SHALL be 2 edges (TURN, then IDLE decision).
REQ-022 Re-arbitration SHALL occur only in IDLE; requests arriving in GRANT, BUSY or TURN SHALL wait.
REQ-023 If a request and the winner's deassertion occur on the same IDLE edge, the sampled value SHALL win; REQ-017 SHALL handle the drop.
REQ-024 A no-show counter SHALL count GRANT cycles; at NOSHOW_CYCLES with frame_n still 1, the arbiter SHALL drop the grant, pulse timeout, and enter TURN.
REQ-025 At most one gnt_n bit SHALL be low in any cycle.

Reset
REQ-026 While reset=1, outputs SHALL be: gnt_n=4'b1111, owner=2'd3, timeout=0, state IDLE, counters 0.
REQ-027 Reset SHALL remove the grant asynchronously, even mid-transaction.
REQ-028 After reset release, master 0 SHALL have the highest priority.

Configuration
REQ-029 With ARB_TIMEOUT_EN defined, a latency counter SHALL count GRANT+BUSY cycles while any other req_n is low.
REQ-030 At TIMEOUT_CYCLES, the arbiter SHALL deassert the grant, pulse timeout, and wait in BUSY for the bus to go idle.
REQ-031 Without ARB_TIMEOUT_EN, no latency counter SHALL exist; the owner SHALL keep the grant until it releases req_n. The no-show timer stays.

Structure
REQ-032 Package pci_arb_pkg SHALL hold the state encoding, NUM_MASTERS=4, and the counter width.
REQ-033 The round-robin priority picker SHALL be sub-module rr_picker (combinational: inputs req vector and last owner; outputs winner index and valid).

Verification
REQ-034 Reset, then req_n=4'b0000 -> next edge gnt_n=4'b1110, owner=0.
REQ-035 Master 0 does frame_n low 3 cycles then releases, with req_n[1] and req_n[2] held low -> TURN 1 cycle, then gnt_n=4'b1101; after its release, gnt_n=4'b1011.
REQ-036 Grant to master 2; frame_n held high for 16 cycles -> gnt_n=4'b1111, timeout pulses once, TURN, re-arbitration.
REQ-037 With ARB_TIMEOUT_EN, master 1 in BUSY and req_n[3]=0 for 16 cycles -> grant removed and timeout=1; after frame_n/irdy_n go high, TURN then gnt_n=4'b0111.
REQ-038 Reset asserted mid-BUSY -> gnt_n=4'b1111 immediately (same cycle, no edge); after release, master 0 has priority.
REQ-039 Random requests for 10k cycles -> gnt_n is never more than one bit low, and no master with a request goes more than 3 grants without service.
